// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single data-memory port between the pipeline MEM stage and a
// DMA requester (UART loader / block-copy engine). The CPU normally wins,
// DMA uses idle cycles and may lock the port for a burst, and a starvation
// counter forces a waiting DMA beat through after MAX_WAIT lost cycles.
// The owner is picked combinationally every cycle; nothing is registered on
// the data path, so a served access completes in the same cycle.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   cpu_rd/wr/addr/wdata  MEM-stage request (held stable while stalled)
//   cpu_rdata             read data back to MEM stage (= mem_rdata)
//   cpu_stall             CPU request present but not served this cycle
//   dma_req/wr/last       DMA beat request, direction, last-beat marker
//   dma_addr/wdata        DMA beat address and write data
//   dma_rdata             read data back to DMA (= mem_rdata, valid on ack)
//   dma_ack               DMA beat served this cycle
//   dma_busy              burst lock held
//   mem_addr/wdata/rd/wr  to DataMem
//   mem_rdata             combinational read data from DataMem
module dmem_port_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic        dma_last,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        dma_busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, DMA_BURST} state_t;

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_SAT   = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BEAT_FINAL = BW'(BURST_MAX - 1);

  state_t        st;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_cnt;

  logic cpu_req;
  logic starve;
  logic serve_dma;
  logic serve_cpu;
  logic burst_done;

  assign cpu_req    = cpu_rd | cpu_wr;
  assign starve     = (wait_cnt == WAIT_SAT);
  // beat_cnt holds beats already served, so this beat is the BURST_MAX-th one
  assign burst_done = (beat_cnt == BEAT_FINAL);

  // Grant decision. Reset masks both grants so no memory strobe or ack can
  // escape while reset is held, even with a burst in flight.
  always_comb begin
    serve_dma = 1'b0;
    serve_cpu = 1'b0;
    if (!reset) begin
      if (st == DMA_BURST) begin
        serve_dma = dma_req;
      end else begin
        serve_dma = dma_req & (~cpu_req | starve);
      end
      serve_cpu = cpu_req & ~serve_dma;
    end
  end

  assign cpu_stall = cpu_req & ~serve_cpu & ~reset;
  assign dma_ack   = serve_dma;
  assign dma_busy  = (st == DMA_BURST) & ~reset;
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

  // Port mux. When the DMA does not own the port the CPU fields drive the
  // address/data lines, with strobes only when the CPU is actually served.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_rd    = cpu_rd & serve_cpu;
    mem_wr    = cpu_wr & serve_cpu;
    if (serve_dma) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_rd    = ~dma_wr;
      mem_wr    = dma_wr;
    end
  end

  // Burst lock and starvation tracking. wait_cnt only grows while a DMA
  // request loses in IDLE; every way out of a burst clears it, which hands
  // the CPU at least one priority cycle after a forced release.
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (serve_dma) begin
            wait_cnt <= '0;
            if (!dma_last && (BURST_MAX > 1)) begin
              st       <= DMA_BURST;
              beat_cnt <= BW'(1);
            end
          end else if (dma_req) begin
            if (!starve) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        DMA_BURST: begin
          wait_cnt <= '0;
          if (!dma_req) begin
            st       <= IDLE;
            beat_cnt <= '0;
          end else if (dma_last || burst_done) begin
            st       <= IDLE;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          st       <= IDLE;
          wait_cnt <= '0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Directed scenarios followed by randomized traffic. Every cycle the DUT
// outputs are compared with a reference model that reasons in terms of
// "is the port locked by a burst", "how many beats in this burst" and
// "how many cycles has the waiting DMA lost".
module tb_dmem_port_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_wr, dma_last;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack, dma_busy;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_rdata;

  int n_compared   = 0;
  int n_mismatched = 0;

  // reference model state
  bit m_locked = 0;
  int m_beats  = 0;
  int m_losses = 0;

  // per-cycle expectations and DUT snapshots for directed checks
  bit          e_dma, e_cpu, e_stall;
  logic        obs_ack, obs_stall, obs_busy, obs_mem_rd, obs_mem_wr;
  logic [31:0] obs_addr;

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_last(dma_last),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
    .dma_ack(dma_ack), .dma_busy(dma_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; sample at the falling edge,
  // compare against the model, advance the model, then step past the rise.
  task automatic applyStimulus();
    bit cpu_req;
    @(negedge clk);
    cpu_req = cpu_rd | cpu_wr;
    if (reset) begin
      e_dma = 0;
      e_cpu = 0;
    end else begin
      if (m_locked) e_dma = dma_req;
      else          e_dma = dma_req && (!cpu_req || m_losses == MAX_WAIT);
      e_cpu = cpu_req && !e_dma;
    end
    e_stall = !reset && cpu_req && !e_cpu;

    checkOutput("dma_ack",   {31'd0, dma_ack},   {31'd0, e_dma});
    checkOutput("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
    checkOutput("dma_busy",  {31'd0, dma_busy},  {31'd0, !reset && m_locked});
    checkOutput("mem_rd", {31'd0, mem_rd},
                {31'd0, e_dma ? !dma_wr : (cpu_rd && e_cpu)});
    checkOutput("mem_wr", {31'd0, mem_wr},
                {31'd0, e_dma ? dma_wr : (cpu_wr && e_cpu)});
    if (e_dma || e_cpu) begin
      checkOutput("mem_addr",  mem_addr,  e_dma ? dma_addr  : cpu_addr);
      checkOutput("mem_wdata", mem_wdata, e_dma ? dma_wdata : cpu_wdata);
    end
    checkOutput("cpu_rdata", cpu_rdata, mem_rdata);
    checkOutput("dma_rdata", dma_rdata, mem_rdata);

    obs_ack    = dma_ack;
    obs_stall  = cpu_stall;
    obs_busy   = dma_busy;
    obs_mem_rd = mem_rd;
    obs_mem_wr = mem_wr;
    obs_addr   = mem_addr;

    if (reset) begin
      m_locked = 0;
      m_beats  = 0;
      m_losses = 0;
    end else if (m_locked) begin
      m_losses = 0;
      if (!dma_req) begin
        m_locked = 0;
      end else begin
        m_beats++;
        if (dma_last || m_beats >= BURST_MAX) m_locked = 0;
      end
    end else if (e_dma) begin
      m_losses = 0;
      if (!dma_last && BURST_MAX > 1) begin
        m_locked = 1;
        m_beats  = 1;
      end
    end else if (dma_req) begin
      if (m_losses < MAX_WAIT) m_losses++;
    end else begin
      m_losses = 0;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_wr = 0; dma_last = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  initial begin
    int beats;
    bit exp_ack, exp_stall, exp_busy;

    reset = 1;
    idleInputs();
    mem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;

    // reset masks strobes even with both sides requesting
    cpu_rd = 1; dma_req = 1; dma_wr = 1; dma_last = 1;
    applyStimulus();
    checkOutput("rst_ack",   {31'd0, obs_ack},    32'd0);
    checkOutput("rst_stall", {31'd0, obs_stall},  32'd0);
    checkOutput("rst_memwr", {31'd0, obs_mem_wr}, 32'd0);
    checkOutput("rst_busy",  {31'd0, obs_busy},   32'd0);

    // CPU-only store
    reset = 0;
    idleInputs();
    cpu_wr = 1; cpu_addr = 32'h10; cpu_wdata = 32'hA5A5;
    applyStimulus();
    checkOutput("t1_mem_wr", {31'd0, obs_mem_wr}, 32'd1);
    checkOutput("t1_stall",  {31'd0, obs_stall},  32'd0);
    checkOutput("t1_ack",    {31'd0, obs_ack},    32'd0);
    checkOutput("t1_addr",   obs_addr,            32'h10);

    // single DMA read in an idle cycle
    idleInputs();
    dma_req = 1; dma_wr = 0; dma_last = 1; dma_addr = 32'h20;
    applyStimulus();
    checkOutput("t2_ack",    {31'd0, obs_ack},    32'd1);
    checkOutput("t2_mem_rd", {31'd0, obs_mem_rd}, 32'd1);
    checkOutput("t2_addr",   obs_addr,            32'h20);
    idleInputs();
    applyStimulus();
    checkOutput("t2_busy", {31'd0, obs_busy}, 32'd0);

    // starvation: DMA forced through on the 5th cycle
    cpu_rd = 1; cpu_addr = 32'h30;
    dma_req = 1; dma_wr = 0; dma_last = 1; dma_addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput($sformatf("t3_ack%0d", i),   {31'd0, obs_ack},   {31'd0, i == 4});
      checkOutput($sformatf("t3_stall%0d", i), {31'd0, obs_stall}, {31'd0, i == 4});
    end

    // 3-beat burst entered through starvation while the CPU keeps loading
    beats = 0;
    dma_wr = 1; dma_addr = 32'h100;
    for (int i = 0; i < 8; i++) begin
      dma_req  = (beats < 3);
      dma_last = (beats == 2);
      dma_addr = 32'h100 + 32'(beats * 4);
      dma_wdata = 32'hD000 + 32'(beats);
      applyStimulus();
      if (e_dma) beats++;
      exp_ack  = (i >= 4 && i <= 6);
      exp_busy = (i == 5 || i == 6);
      checkOutput($sformatf("t4_ack%0d", i),   {31'd0, obs_ack},   {31'd0, exp_ack});
      checkOutput($sformatf("t4_stall%0d", i), {31'd0, obs_stall}, {31'd0, exp_ack});
      checkOutput($sformatf("t4_busy%0d", i),  {31'd0, obs_busy},  {31'd0, exp_busy});
    end

    // 12-beat burst: forced release after 8, CPU gets a cycle, DMA resumes
    idleInputs();
    applyStimulus();
    beats = 0;
    for (int i = 0; i < 17; i++) begin
      cpu_rd = (i >= 1); cpu_addr = 32'h200;
      dma_req = (beats < 12); dma_wr = 1; dma_last = (beats == 11);
      dma_addr = 32'h300 + 32'(beats * 4);
      applyStimulus();
      if (e_dma) beats++;
      exp_ack   = (i <= 7) || (i >= 12 && i <= 15);
      exp_stall = exp_ack && (i >= 1);
      checkOutput($sformatf("t5_ack%0d", i),   {31'd0, obs_ack},   {31'd0, exp_ack});
      checkOutput($sformatf("t5_stall%0d", i), {31'd0, obs_stall}, {31'd0, exp_stall});
    end

    // reset during beat 2 of a burst
    idleInputs();
    applyStimulus();
    dma_req = 1; dma_wr = 1; dma_last = 0; dma_addr = 32'h400;
    applyStimulus();
    checkOutput("t6_beat1", {31'd0, obs_ack}, 32'd1);
    reset = 1;
    applyStimulus();
    checkOutput("t6_memwr", {31'd0, obs_mem_wr}, 32'd0);
    checkOutput("t6_ack",   {31'd0, obs_ack},    32'd0);
    reset = 0;
    cpu_rd = 1;
    applyStimulus();
    checkOutput("t6_busy", {31'd0, obs_busy}, 32'd0);
    checkOutput("t6_ack2", {31'd0, obs_ack},  32'd0);

    // randomized traffic
    idleInputs();
    e_stall = 0;
    e_dma = 0;
    for (int i = 0; i < 3000; i++) begin
      bit was_reset;
      was_reset = reset;
      reset = ($urandom_range(0, 199) == 0);
      if (!e_stall || was_reset) begin
        case ($urandom_range(0, 3))
          0:       begin cpu_rd = 1; cpu_wr = 0; end
          1:       begin cpu_rd = 0; cpu_wr = 1; end
          default: begin cpu_rd = 0; cpu_wr = 0; end
        endcase
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
      if (dma_req && !e_dma && !was_reset) begin
        if ($urandom_range(0, 19) == 0) dma_req = 0;
      end else begin
        dma_req   = ($urandom_range(0, 2) != 0);
        dma_wr    = $urandom_range(0, 1) == 1;
        dma_last  = ($urandom_range(0, 5) == 0);
        dma_addr  = $urandom;
        dma_wdata = $urandom;
      end
      mem_rdata = $urandom;
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
